// File: rtl/aes_uart_sequencer.sv
// aes_uart_sequencer: turns a byte-framed UART command stream into AES core
// operations. 'K' + 16 bytes loads the key, 'E' + 16 bytes encrypts one block.
// Each command returns ACK/NAK, 0xEE on a core timeout, or the 16-byte
// ciphertext, MSB byte first.
//
// state          | meaning
// ---------------+------------------------------------------------------
// S_IDLE         | waiting for a command byte
// S_RX_KEY       | collecting 16 key bytes into the staging register
// S_RX_DATA      | collecting 16 plaintext bytes
// S_AES_RUN      | core started, waiting for aes_done or the timeout
// S_TX_LOAD      | waiting for an idle transmitter, then handing it a byte
// S_TX_WAIT_BUSY | waiting for the transmitter to report busy
// S_TX_WAIT_IDLE | waiting for the transmitter to finish the byte

module aes_uart_sequencer #(
    parameter int RX_TIMEOUT  = 1_000_000,
    parameter int AES_TIMEOUT = 4096
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         uart_rx_ready,
    input  logic [7:0]   uart_data_from_rx,
    input  logic         uart_tx_ready,
    output logic         uart_tx_enable,
    output logic [7:0]   uart_data_to_tx,
    output logic [127:0] aes_key,
    output logic [127:0] aes_din,
    output logic         aes_start,
    input  logic         aes_done,
    input  logic [127:0] aes_dout,
    output logic         busy,
    output logic         key_valid,
    output logic         err_overrun
);

    localparam int RX_TW  = $clog2(RX_TIMEOUT + 1);
    localparam int AES_TW = $clog2(AES_TIMEOUT + 1);

    // Timers count down from limit-1; terminal count 0 in a waiting cycle
    // means the full limit has elapsed.
    localparam logic [RX_TW-1:0]  RX_LOAD  = RX_TW'(RX_TIMEOUT - 1);
    localparam logic [AES_TW-1:0] AES_LOAD = AES_TW'(AES_TIMEOUT - 1);

    localparam logic [7:0] CMD_KEY = 8'h4B;
    localparam logic [7:0] CMD_ENC = 8'h45;
    localparam logic [7:0] RSP_ACK = 8'h06;
    localparam logic [7:0] RSP_NAK = 8'h15;
    localparam logic [7:0] RSP_ERR = 8'hEE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX_KEY,
        S_RX_DATA,
        S_AES_RUN,
        S_TX_LOAD,
        S_TX_WAIT_BUSY,
        S_TX_WAIT_IDLE
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          byte_cnt_q, byte_cnt_d;
    logic [119:0]        rx_shift_q, rx_shift_d;
    logic [127:0]        tx_shift_q, tx_shift_d;
    logic [4:0]          tx_left_q, tx_left_d;
    logic [RX_TW-1:0]    rx_tmr_q, rx_tmr_d;
    logic [AES_TW-1:0]   aes_tmr_q, aes_tmr_d;

    logic                tx_en_d;
    logic [7:0]          tx_data_d;
    logic [127:0]        key_d;
    logic [127:0]        din_d;
    logic                start_d;
    logic                busy_d;
    logic                key_valid_d;
    logic                overrun_d;
    logic [127:0]        rx_word;

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        tx_left_d   = tx_left_q;
        rx_tmr_d    = rx_tmr_q;
        aes_tmr_d   = aes_tmr_q;
        tx_en_d     = 1'b0;
        tx_data_d   = uart_data_to_tx;
        key_d       = aes_key;
        din_d       = aes_din;
        start_d     = 1'b0;
        key_valid_d = key_valid;
        overrun_d   = err_overrun;
        rx_word     = {rx_shift_q, uart_data_from_rx};

        // Bytes arriving while the block is not receiving are lost.
        if (uart_rx_ready && (state_q inside {S_AES_RUN, S_TX_LOAD,
                                              S_TX_WAIT_BUSY, S_TX_WAIT_IDLE}))
            overrun_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (uart_rx_ready) begin
                    byte_cnt_d = 4'd0;
                    rx_tmr_d   = RX_LOAD;
                    case (uart_data_from_rx)
                        CMD_KEY: state_d = S_RX_KEY;
                        CMD_ENC: state_d = S_RX_DATA;
                        default: begin
                            tx_shift_d = {RSP_NAK, 120'd0};
                            tx_left_d  = 5'd1;
                            state_d    = S_TX_LOAD;
                        end
                    endcase
                end
            end
            S_RX_KEY, S_RX_DATA: begin
                if (uart_rx_ready) begin
                    rx_shift_d = rx_word[119:0];
                    byte_cnt_d = byte_cnt_q + 4'd1;
                    rx_tmr_d   = RX_LOAD;
                    if (byte_cnt_q == 4'hF) begin
                        if (state_q == S_RX_KEY) begin
                            key_d       = rx_word;
                            key_valid_d = 1'b1;
                            tx_shift_d  = {RSP_ACK, 120'd0};
                            tx_left_d   = 5'd1;
                            state_d     = S_TX_LOAD;
                        end else begin
                            din_d = rx_word;
                            if (key_valid) begin
                                start_d   = 1'b1;
                                aes_tmr_d = AES_LOAD;
                                state_d   = S_AES_RUN;
                            end else begin
                                tx_shift_d = {RSP_NAK, 120'd0};
                                tx_left_d  = 5'd1;
                                state_d    = S_TX_LOAD;
                            end
                        end
                    end
                end else if (rx_tmr_q == '0) begin
                    // Partial frame dropped; key state is left untouched.
                    tx_shift_d = {RSP_NAK, 120'd0};
                    tx_left_d  = 5'd1;
                    state_d    = S_TX_LOAD;
                end else begin
                    rx_tmr_d = rx_tmr_q - RX_TW'(1);
                end
            end
            S_AES_RUN: begin
                // A result in the limit cycle still counts as on time.
                if (aes_done) begin
                    tx_shift_d = aes_dout;
                    tx_left_d  = 5'd16;
                    state_d    = S_TX_LOAD;
                end else if (aes_tmr_q == '0) begin
                    tx_shift_d = {RSP_ERR, 120'd0};
                    tx_left_d  = 5'd1;
                    state_d    = S_TX_LOAD;
                end else begin
                    aes_tmr_d = aes_tmr_q - AES_TW'(1);
                end
            end
            S_TX_LOAD: begin
                if (uart_tx_ready) begin
                    tx_en_d    = 1'b1;
                    tx_data_d  = tx_shift_q[127:120];
                    tx_shift_d = {tx_shift_q[119:0], 8'h00};
                    tx_left_d  = tx_left_q - 5'd1;
                    state_d    = S_TX_WAIT_BUSY;
                end
            end
            S_TX_WAIT_BUSY: begin
                if (!uart_tx_ready)
                    state_d = S_TX_WAIT_IDLE;
            end
            S_TX_WAIT_IDLE: begin
                if (uart_tx_ready)
                    state_d = (tx_left_q != 5'd0) ? S_TX_LOAD : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            byte_cnt_q      <= 4'd0;
            rx_shift_q      <= '0;
            tx_shift_q      <= '0;
            tx_left_q       <= 5'd0;
            rx_tmr_q        <= '0;
            aes_tmr_q       <= '0;
            uart_tx_enable  <= 1'b0;
            uart_data_to_tx <= 8'h00;
            aes_key         <= '0;
            aes_din         <= '0;
            aes_start       <= 1'b0;
            busy            <= 1'b0;
            key_valid       <= 1'b0;
            err_overrun     <= 1'b0;
        end else begin
            state_q         <= state_d;
            byte_cnt_q      <= byte_cnt_d;
            rx_shift_q      <= rx_shift_d;
            tx_shift_q      <= tx_shift_d;
            tx_left_q       <= tx_left_d;
            rx_tmr_q        <= rx_tmr_d;
            aes_tmr_q       <= aes_tmr_d;
            uart_tx_enable  <= tx_en_d;
            uart_data_to_tx <= tx_data_d;
            aes_key         <= key_d;
            aes_din         <= din_d;
            aes_start       <= start_d;
            busy            <= busy_d;
            key_valid       <= key_valid_d;
            err_overrun     <= overrun_d;
        end
    end

endmodule

// File: tb/tb_aes_uart_sequencer.sv
// Testbench for aes_uart_sequencer: directed command sequence with random
// payloads, a UART transmitter model and an AES core stand-in.

module tb_aes_uart_sequencer;

    localparam int RX_TO  = 60;
    localparam int AES_TO = 40;

    localparam logic [7:0] C_K  = 8'h4B;
    localparam logic [7:0] C_E  = 8'h45;
    localparam logic [7:0] ACK  = 8'h06;
    localparam logic [7:0] NAK  = 8'h15;
    localparam logic [7:0] AERR = 8'hEE;

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk;
    logic         rst;
    logic         uart_rx_ready;
    logic [7:0]   uart_data_from_rx;
    logic         uart_tx_ready;
    logic         uart_tx_enable;
    logic [7:0]   uart_data_to_tx;
    logic [127:0] aes_key;
    logic [127:0] aes_din;
    logic         aes_start;
    logic         aes_done;
    logic [127:0] aes_dout;
    logic         busy;
    logic         key_valid;
    logic         err_overrun;

    int n_cmp = 0;
    int n_err = 0;
    int n_starts = 0;
    int exp_starts = 0;
    int core_lat = 3;
    bit core_withhold = 1'b0;
    logic [7:0] tx_q[$];

    logic [127:0] m_key;
    logic         m_kv;

    aes_uart_sequencer #(
        .RX_TIMEOUT (RX_TO),
        .AES_TIMEOUT(AES_TO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .uart_rx_ready    (uart_rx_ready),
        .uart_data_from_rx(uart_data_from_rx),
        .uart_tx_ready    (uart_tx_ready),
        .uart_tx_enable   (uart_tx_enable),
        .uart_data_to_tx  (uart_data_to_tx),
        .aes_key          (aes_key),
        .aes_din          (aes_din),
        .aes_start        (aes_start),
        .aes_done         (aes_done),
        .aes_dout         (aes_dout),
        .busy             (busy),
        .key_valid        (key_valid),
        .err_overrun      (err_overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    // Stand-in core: the real FIPS answer for the FIPS vector, otherwise a
    // fixed mixing function of key and plaintext.
    function automatic logic [127:0] core_f(input logic [127:0] k, input logic [127:0] d);
        if (k == FIPS_KEY && d == FIPS_PT)
            return FIPS_CT;
        return k ^ {d[63:0], d[127:64]} ^ 128'h5a5a_0f0f_3c3c_a5a5_1234_5678_9abc_def0;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // UART transmitter model: takes a byte on tx_enable, stays busy 2..5 cycles.
    initial begin
        uart_tx_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (uart_tx_enable) begin
                tx_q.push_back(uart_data_to_tx);
                uart_tx_ready = 1'b0;
                repeat ($urandom_range(2, 5)) @(posedge clk);
                #1;
                uart_tx_ready = 1'b1;
            end
        end
    end

    // AES core model with programmable latency; also checks done-to-TX latency.
    initial begin
        logic [127:0] k_snap, d_snap;
        logic         rdy;
        aes_done = 1'b0;
        aes_dout = '0;
        forever begin
            @(posedge clk); #1;
            if (aes_start) begin
                n_starts++;
                if (!core_withhold) begin
                    k_snap = aes_key;
                    d_snap = aes_din;
                    repeat (core_lat) @(posedge clk);
                    #1;
                    aes_dout = core_f(k_snap, d_snap);
                    aes_done = 1'b1;
                    rdy = uart_tx_ready;
                    @(posedge clk); #1;
                    aes_done = 1'b0;
                    @(posedge clk); #1;
                    if (rdy)
                        check("done_to_tx", uart_tx_enable, 1'b1);
                end
            end
        end
    end

    // Strobes may never stay high on two consecutive cycles.
    initial begin
        logic prev_en, prev_st;
        prev_en = 1'b0;
        prev_st = 1'b0;
        forever begin
            @(negedge clk);
            if (uart_tx_enable) check("tx_en_single", prev_en, 1'b0);
            if (aes_start) check("start_single", prev_st, 1'b0);
            prev_en = uart_tx_enable;
            prev_st = aes_start;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        uart_rx_ready = 1'b1;
        uart_data_from_rx = b;
        @(negedge clk);
        uart_rx_ready = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    // tie_idx: the gap after that payload byte equals the timeout limit exactly.
    task automatic send_frame(input logic [7:0] cmd, input logic [127:0] payload,
                              input int gap, input int tie_idx);
        int g;
        send_byte(cmd, gap);
        for (int i = 0; i < 16; i++) begin
            g = (i == 15) ? 0 : ((i == tie_idx) ? RX_TO - 1 : gap);
            send_byte(payload[127-8*i -: 8], g);
        end
    endtask

    task automatic expect_resp(input string tag, input int n, input logic [127:0] exp);
        int w;
        logic [7:0] got;
        w = 0;
        while (tx_q.size() < n && w < 3000) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_count"}, tx_q.size(), n);
        for (int i = 0; i < n; i++) begin
            got = (tx_q.size() > 0) ? tx_q.pop_front() : 8'hxx;
            check(tag, got, exp[127-8*i -: 8]);
        end
        w = 0;
        while (busy !== 1'b0 && w < 300) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_idle"}, busy, 1'b0);
        repeat (3) @(negedge clk);
        check({tag, "_extra"}, tx_q.size(), 0);
    endtask

    task automatic do_key(input logic [127:0] payload, input int gap, input int tie_idx);
        send_frame(C_K, payload, gap, tie_idx);
        m_key = payload;
        m_kv  = 1'b1;
        expect_resp("ack", 1, {ACK, 120'd0});
        check("key_valid", key_valid, m_kv);
        check("aes_key", aes_key, m_key);
    endtask

    // Returns at the negedge right after the 16th data byte was captured.
    task automatic send_enc(input logic [127:0] payload, input int gap);
        send_frame(C_E, payload, gap, -1);
        check("start_pulse", aes_start, m_kv);
        check("aes_din", aes_din, payload);
        if (m_kv) exp_starts++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_key_valid"}, key_valid, 1'b0);
        check({tag, "_overrun"}, err_overrun, 1'b0);
        check({tag, "_tx_en"}, uart_tx_enable, 1'b0);
        check({tag, "_start"}, aes_start, 1'b0);
        check({tag, "_key"}, aes_key, 128'd0);
        check({tag, "_din"}, aes_din, 128'd0);
        check({tag, "_tx_data"}, uart_data_to_tx, 8'h00);
    endtask

    initial begin
        logic [127:0] pt, key;
        logic [7:0]   cmd;
        int           w;

        rst = 1'b1;
        uart_rx_ready = 1'b0;
        uart_data_from_rx = 8'h00;
        m_key = '0;
        m_kv  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Encrypt before any key: NAK, core untouched.
        pt = {$urandom, $urandom, $urandom, $urandom};
        send_enc(pt, 1);
        expect_resp("nokey_nak", 1, {NAK, 120'd0});
        check("nokey_starts", n_starts, exp_starts);
        check("nokey_kv", key_valid, 1'b0);

        // Unknown command: exactly one NAK.
        send_byte(8'h41, 0);
        expect_resp("unknown_nak", 1, {NAK, 120'd0});

        // FIPS-197 vector; key frame back-to-back with one byte on the timeout limit.
        do_key(FIPS_KEY, 0, 7);
        core_lat = 3;
        send_enc(FIPS_PT, 0);
        expect_resp("fips_ct", 16, FIPS_CT);
        check("fips_starts", n_starts, exp_starts);

        // Inter-byte timeout mid key frame.
        send_byte(C_K, 1);
        for (int i = 0; i < 7; i++) send_byte(8'($urandom), 0);
        w = 0;
        while (tx_q.size() == 0 && w < RX_TO + 50) begin
            @(negedge clk);
            w++;
        end
        check("rx_timeout_cycles", w, RX_TO + 1);
        expect_resp("rx_timeout_nak", 1, {NAK, 120'd0});
        check("rx_timeout_key", aes_key, m_key);
        check("rx_timeout_kv", key_valid, m_kv);

        // Random keys and blocks; first round returns on the AES limit cycle.
        for (int r = 0; r < 4; r++) begin
            cmd = 8'($urandom);
            if (cmd == C_K || cmd == C_E) cmd = cmd ^ 8'h80;
            send_byte(cmd, 1);
            expect_resp("rand_cmd_nak", 1, {NAK, 120'd0});
            key = {$urandom, $urandom, $urandom, $urandom};
            do_key(key, $urandom_range(0, 2), -1);
            pt = {$urandom, $urandom, $urandom, $urandom};
            core_lat = (r == 0) ? AES_TO - 1 : $urandom_range(1, 20);
            send_enc(pt, $urandom_range(0, 2));
            expect_resp("rand_ct", 16, core_f(m_key, pt));
            check("rand_starts", n_starts, exp_starts);
        end

        // Core never answers; a byte arriving meanwhile is dropped.
        core_withhold = 1'b1;
        pt = {$urandom, $urandom, $urandom, $urandom};
        send_enc(pt, 1);
        w = 0;
        while (tx_q.size() == 0 && w < AES_TO + 50) begin
            uart_rx_ready = (w == 5);
            uart_data_from_rx = C_K;
            @(negedge clk);
            w++;
        end
        uart_rx_ready = 1'b0;
        check("aes_timeout_cycles", w, AES_TO + 1);
        check("overrun_set", err_overrun, 1'b1);
        expect_resp("aes_timeout_ee", 1, {AERR, 120'd0});
        core_withhold = 1'b0;
        check("aes_timeout_starts", n_starts, exp_starts);
        send_byte(8'h00, 0);
        expect_resp("post_ovr_nak", 1, {NAK, 120'd0});
        check("overrun_sticky", err_overrun, 1'b1);
        check("post_ovr_key", aes_key, m_key);

        // Reset while the 9th ciphertext byte is in flight.
        core_lat = 2;
        pt = {$urandom, $urandom, $urandom, $urandom};
        send_enc(pt, 0);
        w = 0;
        while (tx_q.size() < 9 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        check("mid_tx_reached", tx_q.size() >= 9, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        rst = 1'b0;
        tx_q.delete();
        m_key = '0;
        m_kv  = 1'b0;
        key = {$urandom, $urandom, $urandom, $urandom};
        do_key(key, 1, -1);
        check("after_reset_overrun", err_overrun, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/aes_uart_sequencer.md
# aes_uart_sequencer

Command sequencer between the UART byte interface and a 128-bit AES encryption core. It parses a byte-framed command stream from the UART receiver, assembles 128-bit key and plaintext blocks, and starts the core. It returns the ciphertext, or an ACK/NAK byte, through the UART transmitter. It sits between `uart` and the AES core inside the AES top level and owns all sequencing of the core.

## Interface
Parameters:
- `RX_TIMEOUT`, default 1_000_000: maximum clk cycles between bytes inside a frame.
- `AES_TIMEOUT`, default 4096: maximum clk cycles from `aes_start` to `aes_done`.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `uart_rx_ready` in 1: one-cycle strobe; `uart_data_from_rx` is valid in the same cycle.
- `uart_data_from_rx` in 8: received byte.
- `uart_tx_ready` in 1: high while the transmitter is idle.
- `uart_tx_enable` out 1: one-cycle strobe; the transmitter accepts `uart_data_to_tx`.
- `uart_data_to_tx` out 8: byte to send.
- `aes_key` out 128: key register.
- `aes_din` out 128: plaintext register.
- `aes_start` out 1: one-cycle start strobe to the core.
- `aes_done` in 1: one-cycle strobe; `aes_dout` is valid in the same cycle.
- `aes_dout` in 128: ciphertext.
- `busy` out 1: high in every state except IDLE.
- `key_valid` out 1: high once a key frame has completed.
- `err_overrun` out 1: sticky; set when a byte arrives while the block is not receiving.

## Operation
- States: IDLE, RX_KEY, RX_DATA, AES_RUN, TX_LOAD, TX_WAIT_BUSY, TX_WAIT_IDLE.
- IDLE accepts a command byte:
  - 0x4B ('K') goes to RX_KEY.
  - 0x45 ('E') goes to RX_DATA.
  - Any other byte queues a NAK (0x15) and goes to TX_LOAD.
- RX_KEY and RX_DATA collect 16 bytes into a 4-bit `byte_cnt`.
  - The first byte received lands in bits [127:120]. Each later byte shifts in at [7:0].
  - RX_KEY shifts into a staging register. `aes_key` and `key_valid` update only on the 16th byte.
  - On the 16th key byte the block queues ACK (0x06) and goes to TX_LOAD.
- On the 16th data byte:
  - If `key_valid` is 0: queue NAK and go to TX_LOAD. The data is consumed and the core is not started.
  - Otherwise: pulse `aes_start` and go to AES_RUN.
- AES_RUN waits for `aes_done`.
  - On `aes_done`, latch `aes_dout` into a 128-bit TX shift register, set the send length to 16, and go to TX_LOAD.
  - If `AES_TIMEOUT` cycles pass without `aes_done`, queue 0xEE and go to TX_LOAD.
- Ciphertext is sent MSB byte first ([127:120] first).
- TX_LOAD waits for `uart_tx_ready`=1, then pulses `uart_tx_enable` with the current byte and goes to TX_WAIT_BUSY.
- TX_WAIT_BUSY waits for `uart_tx_ready`=0, then goes to TX_WAIT_IDLE.
- TX_WAIT_IDLE waits for `uart_tx_ready`=1. It then returns to TX_LOAD if bytes remain, otherwise to IDLE.
- Inter-byte timeout: the counter resets on every accepted byte in RX_KEY or RX_DATA. On reaching `RX_TIMEOUT`:
  - Discard the partial frame. `aes_key` and `key_valid` keep their prior values.
  - Queue NAK and go to TX_LOAD.
- A `uart_rx_ready` strobe in AES_RUN or any TX state drops the byte and sets `err_overrun`. Only `rst` clears `err_overrun`.
- A new key frame that times out leaves the previous key in use.

## Timing
- Reset values:
  - State IDLE.
  - All strobes 0, `busy` 0, `key_valid` 0, `err_overrun` 0.
  - `aes_key`, `aes_din` and `uart_data_to_tx` all zero.
- `rst` takes effect at the next clk edge from any state, including mid-frame, AES_RUN and TX.
  - An in-flight core result arriving after reset is ignored.
  - Any byte already handed to the UART is the UART's responsibility.
- `aes_din` updates in the same edge that captures the 16th data byte.
- `aes_start` is high in the cycle after that edge, for exactly one cycle.
- `aes_done` to the first `uart_tx_enable`: 2 cycles when `uart_tx_ready` is already 1.
- Command byte to state change: 1 cycle. One byte is consumed per `uart_rx_ready` strobe, so back-to-back strobes on consecutive cycles are accepted.
- If `aes_done` and the timeout limit occur in the same cycle, `aes_done` wins.
- If `uart_rx_ready` and the RX timeout limit occur in the same cycle, the byte wins and the timeout counter resets.
- All outputs are registered. `uart_tx_enable` and `aes_start` are never high for two consecutive cycles.

## Test plan
- FIPS-197 known answer:
  - Send 'K' followed by 00 01 … 0F. Expect ACK 0x06 and `key_valid`=1.
  - Then send 'E' followed by 00 11 22 … FF. Expect one `aes_start` pulse, `aes_din`=00112233…eeff, and TX bytes 69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a in that order.
- Encrypt with no key: after reset send 'E' plus 16 bytes. Expect NAK 0x15, no `aes_start`, `key_valid` still 0.
- Unknown command: send 0x41. Expect a single NAK. The next 'K' frame then completes normally.
- RX timeout: send 'K' plus 7 bytes, then idle for `RX_TIMEOUT` cycles. Expect NAK; `aes_key` and `key_valid` unchanged.
- Overrun and AES timeout:
  - Strobe `uart_rx_ready` during AES_RUN. Expect `err_overrun`=1 and the byte dropped.
  - Withhold `aes_done`. Expect 0xEE after `AES_TIMEOUT` cycles.
- Reset mid-operation: assert `rst` during the 9th ciphertext byte's TX_WAIT_IDLE. Expect every output at its reset value on the next edge, and IDLE accepting a fresh 'K'.
